// File: rtl/multiplexeur_rr_nxw_pkg.sv
// Shared constants, output-stage state type and width helpers for the
// N-channel round-robin / fixed-select multiplexer.
package mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A single channel still needs a one-bit index.
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/multiplexeur_rr_nxw_if.sv
// Handshake bundle between the channel sources, the multiplexer and the
// downstream sink.
interface multiplexeur_rr_nxw_if
    import mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = sel_width(CHANNELS)
);
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic [SEL_W-1:0]          sel;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_ready;

    modport slave (
        input  in_valid, in_data, sel, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );

    modport master (
        output in_valid, in_data, sel, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );
endinterface

// File: rtl/multiplexeur_rr_nxw_arbitre_rr.sv
// Rotating-priority arbiter: searches upward from the channel after the last
// granted one, and only moves its pointer when the grant is actually taken.
module arbitre_rr
    import mux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] req,
    input  logic                advance,
    output logic                grant_valid,
    output logic [SEL_W-1:0]    grant_idx
);

    logic [SEL_W-1:0] last_q;
    logic [SEL_W-1:0] last_d;
    logic [SEL_W-1:0] idx_w;
    int               pos;

    // Walk from farthest to nearest so the nearest requester is written last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        pos         = 0;
        idx_w       = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            pos   = (int'(last_q) + k) % CHANNELS;
            idx_w = SEL_W'(pos);
            if (req[idx_w]) begin
                grant_valid = 1'b1;
                grant_idx   = idx_w;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (advance) begin
            last_d = grant_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= SEL_W'(CHANNELS - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/multiplexeur_rr_nxw.sv
// N-to-1 multiplexer with a one-word registered output stage; the channel is
// chosen either by the sel port or by a round-robin arbiter.
module multiplexeur_rr_nxw
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int MODE     = MODE_RR,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                   clk,
    input  logic                   reset,
    multiplexeur_rr_nxw_if.slave   bus
);

    out_state_e          state_q, state_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [SEL_W-1:0]    out_chan_q, out_chan_d;

    logic                load_en;
    logic                grant_valid;
    logic [SEL_W-1:0]    grant_idx;
    logic                in_xfer;
    logic [CHANNELS-1:0] in_ready_w;
    logic [WIDTH-1:0]    chan_data [CHANNELS];

    assign load_en = (state_q == ST_EMPTY) || bus.out_ready;
    assign in_xfer = load_en && grant_valid && !reset;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic unused_sel;
            assign unused_sel = ^bus.sel;

            arbitre_rr #(.CHANNELS(CHANNELS)) u_arbitre (
                .clk         (clk),
                .reset       (reset),
                .req         (bus.in_valid),
                .advance     (in_xfer),
                .grant_valid (grant_valid),
                .grant_idx   (grant_idx)
            );
        end else begin : g_fixed
            // Out-of-range selects (non power-of-two channel counts) never grant.
            always_comb begin
                grant_idx   = bus.sel;
                grant_valid = 1'b0;
                if (32'(bus.sel) < 32'(CHANNELS)) begin
                    grant_valid = bus.in_valid[bus.sel];
                end
            end
        end
    endgenerate

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        assign in_ready_w[gi] = in_xfer && (grant_idx == SEL_W'(gi));
        assign chan_data[gi]  = bus.in_data[gi*WIDTH +: WIDTH];
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_chan_d = out_chan_q;
        if (in_xfer) begin
            state_d    = ST_FULL;
            out_data_d = chan_data[grant_idx];
            out_chan_d = grant_idx;
        end else if ((state_q == ST_FULL) && bus.out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            out_chan_q <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_chan_q <= out_chan_d;
        end
    end

endmodule

// File: tb/tb_multiplexeur_rr_nxw.sv
// Directed and randomized checks of the multiplexer in round-robin (4 and 5
// channels) and fixed-select (3 channels) configurations.
module tb_multiplexeur_rr_nxw;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multiplexeur_rr_nxw_if #(.WIDTH(8),  .CHANNELS(4)) bus_a ();
    multiplexeur_rr_nxw_if #(.WIDTH(8),  .CHANNELS(3)) bus_f ();
    multiplexeur_rr_nxw_if #(.WIDTH(16), .CHANNELS(5)) bus_r ();

    multiplexeur_rr_nxw #(.WIDTH(8), .CHANNELS(4), .MODE(1)) dut_a (
        .clk(clk), .reset(rst), .bus(bus_a.slave));
    multiplexeur_rr_nxw #(.WIDTH(8), .CHANNELS(3), .MODE(0)) dut_f (
        .clk(clk), .reset(rst), .bus(bus_f.slave));
    multiplexeur_rr_nxw #(.WIDTH(16), .CHANNELS(5), .MODE(1)) dut_r (
        .clk(clk), .reset(rst), .bus(bus_r.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference-model state for the randomized 5-channel run
    int            last_m;
    bit            ov_m;
    logic [15:0]   od_m;
    int            oc_m;
    logic [18:0]   sb_q[$];
    int            miss[5];

    initial begin
        logic [4:0]  iv;
        logic [79:0] dat;
        bit          ordy;
        int          g;
        bit          load;
        logic [18:0] exp_word;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus_a.in_valid = 4'hF; bus_a.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        bus_a.sel = '0; bus_a.out_ready = 1'b1;
        bus_f.in_valid = '0; bus_f.in_data = '0; bus_f.sel = '0; bus_f.out_ready = 1'b1;
        bus_r.in_valid = '0; bus_r.in_data = '0; bus_r.sel = '0; bus_r.out_ready = 1'b1;

        // Reset state, with requests pending
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", bus_a.out_valid, 0);
        chk("rst_out_data",  bus_a.out_data, 0);
        chk("rst_out_chan",  bus_a.out_chan, 0);
        chk("rst_in_ready",  bus_a.in_ready, 0);

        // All four channels requesting: 0,1,2,3,0
        @(negedge clk); rst = 1'b0; #1;
        chk("rr_first_grant", bus_a.in_ready, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk("rr_out_valid", bus_a.out_valid, 1);
            chk("rr_out_chan", bus_a.out_chan, k % 4);
            chk("rr_out_data", bus_a.out_data, 8'h10 + (k % 4));
            chk("rr_in_ready", bus_a.in_ready, 4'b0001 << ((k + 1) % 4));
            $display("step rr k=%0d chan=%0d data=%0h", k, bus_a.out_chan, bus_a.out_data);
        end

        // Only channels 1 and 3 requesting
        bus_a.in_valid = 4'b1010; #1;
        chk("alt_in_ready0", bus_a.in_ready, 4'b0010);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("alt_out_chan", bus_a.out_chan, (k % 2 == 0) ? 1 : 3);
            chk("alt_in_ready", bus_a.in_ready, (k % 2 == 0) ? 4'b1000 : 4'b0010);
            chk("alt_no_even", bus_a.in_ready & 4'b0101, 0);
            $display("step alt k=%0d chan=%0d", k, bus_a.out_chan);
        end

        // Back-pressure holds word and pointer
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        bus_a.in_valid = 4'b0001; bus_a.in_data = {8'h13, 8'h12, 8'h11, 8'hA5}; #1;
        chk("hold_load_ready", bus_a.in_ready, 4'b0001);
        @(negedge clk);
        bus_a.out_ready = 1'b0; bus_a.in_valid = 4'hF; #1;
        chk("hold_load_data", bus_a.out_data, 8'hA5);
        for (int k = 0; k < 5; k++) begin
            chk("hold_in_ready", bus_a.in_ready, 0);
            @(negedge clk);
            bus_a.in_data = $urandom; #1;
            chk("hold_out_data", bus_a.out_data, 8'hA5);
            chk("hold_out_chan", bus_a.out_chan, 0);
            chk("hold_out_valid", bus_a.out_valid, 1);
        end
        bus_a.in_data = {8'h13, 8'h12, 8'h11, 8'hA5};
        bus_a.out_ready = 1'b1; #1;
        chk("hold_next_grant", bus_a.in_ready, 4'b0010);
        @(negedge clk); #1;
        chk("hold_next_chan", bus_a.out_chan, 1);
        chk("hold_next_data", bus_a.out_data, 8'h11);

        // Asynchronous reset while full and stalled
        bus_a.out_ready = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", bus_a.out_valid, 0);
        chk("arst_out_data", bus_a.out_data, 0);
        chk("arst_in_ready", bus_a.in_ready, 0);
        @(negedge clk); rst = 1'b0; bus_a.out_ready = 1'b1; #1;
        chk("arst_first_grant", bus_a.in_ready, 4'b0001);
        @(negedge clk); #1;
        chk("arst_first_chan", bus_a.out_chan, 0);
        bus_a.in_valid = '0;

        // Fixed-select, three channels
        bus_f.sel = 2'd2; bus_f.in_valid = 3'b100;
        bus_f.in_data = {8'h3C, 8'h5A, 8'h77}; #1;
        chk("fix_in_ready", bus_f.in_ready, 3'b100);
        @(negedge clk); #1;
        chk("fix_out_data", bus_f.out_data, 8'h3C);
        chk("fix_out_chan", bus_f.out_chan, 2);
        chk("fix_out_valid", bus_f.out_valid, 1);
        bus_f.sel = 2'd3; bus_f.in_valid = 3'b111; #1;
        chk("fix_oor_ready", bus_f.in_ready, 0);
        @(negedge clk); #1;
        chk("fix_oor_valid", bus_f.out_valid, 0);
        chk("fix_oor_hold", bus_f.out_data, 8'h3C);
        bus_f.sel = 2'd1; bus_f.in_valid = 3'b101; #1;
        chk("fix_novalid_ready", bus_f.in_ready, 0);
        bus_f.sel = 2'd0; #1;
        chk("fix_sel0_ready", bus_f.in_ready, 3'b001);
        @(negedge clk);
        bus_f.out_ready = 1'b0; bus_f.sel = 2'd2; bus_f.in_valid = 3'b111; #1;
        chk("fix_sel0_chan", bus_f.out_chan, 0);
        chk("fix_sel0_data", bus_f.out_data, 8'h77);
        chk("fix_stall_ready", bus_f.in_ready, 0);
        @(negedge clk); #1;
        chk("fix_stall_chan", bus_f.out_chan, 0);
        chk("fix_stall_data", bus_f.out_data, 8'h77);
        bus_f.in_valid = '0;

        // Randomized 5-channel round-robin against the reference model
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        last_m = 4; ov_m = 1'b0; od_m = '0; oc_m = 0;
        for (int i = 0; i < 5; i++) miss[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            iv   = 5'($urandom_range(0, 31));
            dat  = {$urandom, $urandom, $urandom};
            ordy = ($urandom_range(0, 9) < 7);
            bus_r.in_valid = iv; bus_r.in_data = dat; bus_r.out_ready = ordy;
            #1;
            chk("r_out_valid", bus_r.out_valid, ov_m);
            if (ov_m) begin
                chk("r_out_data", bus_r.out_data, od_m);
                chk("r_out_chan", bus_r.out_chan, oc_m);
            end
            if (bus_r.out_valid && ordy) begin
                chk("r_sb_nonempty", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    exp_word = sb_q.pop_front();
                    chk("r_sb_order", {bus_r.out_chan, bus_r.out_data}, exp_word);
                    $display("xfer chan=%0d data=%04h", bus_r.out_chan, bus_r.out_data);
                end
            end
            load = !ov_m || ordy;
            g = -1;
            if (load) begin
                for (int k = 1; k <= 5; k++) begin
                    if (g < 0 && iv[(last_m + k) % 5]) g = (last_m + k) % 5;
                end
            end
            chk("r_in_ready", bus_r.in_ready, (g >= 0) ? (5'b00001 << g) : 5'b0);
            chk("r_onehot0", $onehot0(bus_r.in_ready), 1);
            for (int i = 0; i < 5; i++) begin
                if (!iv[i] || bus_r.in_ready[i]) miss[i] = 0;
                else if (bus_r.in_ready != 0) miss[i]++;
                if (miss[i] > 4) chk("r_starve", miss[i], 4);
            end
            if (g >= 0) begin
                sb_q.push_back({3'(g), dat[g*16 +: 16]});
                ov_m = 1'b1; od_m = dat[g*16 +: 16]; oc_m = g; last_m = g;
            end else if (ov_m && ordy) begin
                ov_m = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiplexeur_rr_nxw.md
MULTIPLEXEUR_RR_NXW -- requirements
Module: multiplexeur_rr_nxw

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data bits per channel (>=1).
REQ-002 SHALL provide parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 SHALL provide parameter MODE, default 1, selection mode: 0 = fixed (sel port), 1 = round-robin.
REQ-004 SHALL derive localparam SEL_W = max(1, clog2(CHANNELS)).
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 in_valid  input  CHANNELS  per-channel request; bit i belongs to channel i.
REQ-009 in_data  input  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-010 in_ready  output  CHANNELS  per-channel accept, combinational, at most one bit set.
REQ-011 sel  input  SEL_W  channel select, used only when MODE=0.
REQ-012 out_valid  output  1  output register holds a word.
REQ-013 out_data  output  WIDTH  registered selected word.
REQ-014 out_chan  output  SEL_W  index of channel that supplied out_data.
REQ-015 out_ready  input  1  downstream accept.

Function
REQ-016 Transfer on input i SHALL occur when in_valid[i] && in_ready[i]; output transfer when out_valid && out_ready.
REQ-017 Output stage SHALL be a 2-state FSM: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-018 load_en SHALL be asserted when state==EMPTY, or state==FULL && out_ready==1.
REQ-019 in_ready[g] SHALL be 1 only for granted channel g, only when load_en and a grant exists; all other bits 0.
REQ-020 MODE=0: grant SHALL be sel if sel<CHANNELS and in_valid[sel]; otherwise no grant.
REQ-021 MODE=1: grant SHALL be first i with in_valid[i]=1 searching from (last+1) mod CHANNELS upward with wrap-around.
REQ-022 Round-robin pointer last SHALL update to g only on an accepted input transfer; unchanged otherwise.
REQ-023 On input transfer, out_data/out_chan SHALL load in_data[g]/g on the next edge; latency 1 cycle input->output.
REQ-024 EMPTY + transfer -> FULL; FULL + out_ready + transfer -> FULL with new word (throughput 1 word/cycle).
REQ-025 FULL + out_ready + no grant -> EMPTY; FULL + !out_ready -> FULL, out_data/out_chan stable.
REQ-026 sel or in_valid changes while FULL && !out_ready SHALL not affect held output.
REQ-027 out_data/out_chan SHALL hold last value when transitioning to EMPTY.
REQ-028 No grant (all in_valid=0) SHALL leave state, pointer and data unchanged except REQ-025.

Reset
REQ-029 On reset: state=EMPTY, out_valid=0, out_data=0, out_chan=0, last=CHANNELS-1 (channel 0 highest priority first).
REQ-030 Reset mid-transfer SHALL drop the held word; in_ready SHALL be all-zero while reset asserted.

Structure
REQ-031 Package mux_pkg SHALL hold MODE_FIXED=0, MODE_RR=1 and the clog2 function.
REQ-032 Rotating-priority grant logic plus pointer register SHALL be sub-module arbitre_rr (params CHANNELS; ports clk, reset, req, advance, grant_valid, grant_idx).
REQ-033 MODE=0 SHALL bypass arbitre_rr via generate; no arbiter flops in fixed mode.

Verification
REQ-034 Reset release, CHANNELS=4, MODE=1, in_valid=4'b1111, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles, out_valid=1 from cycle 1.
REQ-035 MODE=1, in_valid=4'b1010, out_ready=1 -> out_chan alternates 1,3,1,3; in_ready[0],[2] never 1.
REQ-036 MODE=1, out_ready=0 after one load of ch0 data 8'hA5 -> out_data=8'hA5 held, in_ready=0, pointer stays 0 for 5 cycles; out_ready=1 -> next grant ch1.
REQ-037 MODE=0, sel=2, in_valid=4'b0100, in_data[2]=8'h3C -> out_data=8'h3C, out_chan=2 one cycle later; sel=5 with CHANNELS=5-width case (CHANNELS=3, sel=3) -> no grant, out_valid falls.
REQ-038 Assert reset while FULL with out_ready=0 -> out_valid=0, out_data=0 immediately (async); after release, first grant is ch0.
REQ-039 Random stimulus, WIDTH=16, CHANNELS=5: scoreboard checks every accepted word appears once in order, in_ready onehot0, no starvation beyond 4 grants.
